// File: rtl/rock_sequencer.sv
// Cradle rocking sequencer: turns slow tick events into timed forward/pause/reverse/pause
// motor swings, repeats a programmable number of swings, and restarts the count on a cry event.
`timescale 1ns/1ps

module rock_sequencer #(
    parameter int unsigned PHASE_TICKS = 2,
    parameter int unsigned PAUSE_TICKS = 1,
    parameter int unsigned NUM_SWINGS  = 8,
    parameter bit          AUTO_START  = 1'b1
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Tick,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Cry,
    output logic       MotorFwd,
    output logic       MotorRev,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] SwingsLeft
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FWD     = 3'd1,
        ST_PAUSE_F = 3'd2,
        ST_REV     = 3'd3,
        ST_PAUSE_R = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam logic [7:0] PHASE_LAST = 8'(PHASE_TICKS - 1);
    localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_TICKS - 1);
    localparam logic [7:0] NUM_C      = 8'(NUM_SWINGS);

    state_e     state_q, state_d, next_phase_s;
    logic [7:0] pc_q, pc_d, sc_q, sc_d, limit_s;
    logic       tick_q, cry_q;
    logic       tick_ev_s, cry_ev_s, phase_end_s;
    logic       motor_fwd_q, motor_fwd_d, motor_rev_q, motor_rev_d;
    logic       busy_q, busy_d, done_q, done_d;
    logic [7:0] swings_q, swings_d;

    // Next-state, counter and output decode; outputs are computed from the next state so the
    // registered outputs change on the same edge as the state itself.
    always_comb begin
        tick_ev_s   = Tick & ~tick_q;
        cry_ev_s    = Cry & ~cry_q;
        state_d     = state_q;
        pc_d        = pc_q;
        sc_d        = sc_q;

        case (state_q)
            ST_FWD, ST_REV: limit_s = PHASE_LAST;
            default:        limit_s = PAUSE_LAST;
        endcase

        case (state_q)
            ST_FWD:     next_phase_s = ST_PAUSE_F;
            ST_PAUSE_F: next_phase_s = ST_REV;
            ST_REV:     next_phase_s = ST_PAUSE_R;
            default:    next_phase_s = ST_FWD;
        endcase

        phase_end_s = tick_ev_s && (pc_q == limit_s);

        case (state_q)
            ST_IDLE: begin
                if (!Stop && (Start || (cry_ev_s && AUTO_START))) begin
                    state_d = ST_FWD;
                    pc_d    = 8'd0;
                    sc_d    = NUM_C;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FWD, ST_PAUSE_F, ST_REV, ST_PAUSE_R: begin
                if (Stop) begin
                    state_d = ST_IDLE;
                    pc_d    = 8'd0;
                    sc_d    = 8'd0;
                end else begin
                    if (phase_end_s) begin
                        pc_d = 8'd0;
                    end else if (tick_ev_s) begin
                        pc_d = pc_q + 8'd1;
                    end else begin
                        pc_d = pc_q;
                    end

                    // A cry restarts the swing count and also cancels a pending completion.
                    if (cry_ev_s) begin
                        sc_d = NUM_C;
                    end else if (phase_end_s && (state_q == ST_PAUSE_R)) begin
                        sc_d = sc_q - 8'd1;
                    end else begin
                        sc_d = sc_q;
                    end

                    if (!phase_end_s) begin
                        state_d = state_q;
                    end else if ((state_q == ST_PAUSE_R) && (sc_q == 8'd1) && !cry_ev_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = next_phase_s;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                pc_d    = 8'd0;
                sc_d    = 8'd0;
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = 8'd0;
                sc_d    = 8'd0;
            end
        endcase

        motor_fwd_d = (state_d == ST_FWD);
        motor_rev_d = (state_d == ST_REV);
        busy_d      = state_d inside {ST_FWD, ST_PAUSE_F, ST_REV, ST_PAUSE_R};
        done_d      = (state_d == ST_DONE);
        swings_d    = busy_d ? sc_d : 8'd0;
    end

    // State, counters, edge-detect history and registered outputs.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= 8'd0;
            sc_q        <= 8'd0;
            tick_q      <= 1'b0;
            cry_q       <= 1'b0;
            motor_fwd_q <= 1'b0;
            motor_rev_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            swings_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            sc_q        <= sc_d;
            tick_q      <= Tick;
            cry_q       <= Cry;
            motor_fwd_q <= motor_fwd_d;
            motor_rev_q <= motor_rev_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            swings_q    <= swings_d;
        end
    end

    assign MotorFwd   = motor_fwd_q;
    assign MotorRev   = motor_rev_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign SwingsLeft = swings_q;

endmodule

// File: tb/tb_rock_sequencer.sv
// Scoreboard bench for rock_sequencer: three differently configured instances share stimulus,
// a position-based reference model predicts every cycle, and a monitor compares.
`timescale 1ns/1ps

module tb_rock_sequencer;

    logic CLK = 1'b0;
    logic Reset = 1'b1;
    logic Tick = 1'b0, Start = 1'b0, Stop = 1'b0, Cry = 1'b0;

    logic [2:0] fwd_s, rev_s, busy_s, done_s;
    logic [7:0] left_s [3];

    int checks = 0;
    int errors = 0;

    localparam int P0 = 2, Q0 = 1, N0 = 2;
    localparam int P1 = 2, Q1 = 1, N1 = 2;
    localparam int P2 = 3, Q2 = 2, N2 = 3;
    int P_c [3] = '{P0, P1, P2};
    int Q_c [3] = '{Q0, Q1, Q2};
    int N_c [3] = '{N0, N1, N2};
    bit A_c [3] = '{1'b1, 1'b0, 1'b1};

    always #5 CLK = ~CLK;

    rock_sequencer #(.PHASE_TICKS(P0), .PAUSE_TICKS(Q0), .NUM_SWINGS(N0), .AUTO_START(1'b1)) dut_a (
        .CLK(CLK), .Reset(Reset), .Tick(Tick), .Start(Start), .Stop(Stop), .Cry(Cry),
        .MotorFwd(fwd_s[0]), .MotorRev(rev_s[0]), .Busy(busy_s[0]), .Done(done_s[0]),
        .SwingsLeft(left_s[0]));

    rock_sequencer #(.PHASE_TICKS(P1), .PAUSE_TICKS(Q1), .NUM_SWINGS(N1), .AUTO_START(1'b0)) dut_b (
        .CLK(CLK), .Reset(Reset), .Tick(Tick), .Start(Start), .Stop(Stop), .Cry(Cry),
        .MotorFwd(fwd_s[1]), .MotorRev(rev_s[1]), .Busy(busy_s[1]), .Done(done_s[1]),
        .SwingsLeft(left_s[1]));

    rock_sequencer #(.PHASE_TICKS(P2), .PAUSE_TICKS(Q2), .NUM_SWINGS(N2), .AUTO_START(1'b1)) dut_c (
        .CLK(CLK), .Reset(Reset), .Tick(Tick), .Start(Start), .Stop(Stop), .Cry(Cry),
        .MotorFwd(fwd_s[2]), .MotorRev(rev_s[2]), .Busy(busy_s[2]), .Done(done_s[2]),
        .SwingsLeft(left_s[2]));

    // Model: mode 0 idle, 1 rocking, 2 done pulse; pos = tick events into the current swing.
    typedef struct {
        int mode;
        int pos;
        int left;
        bit ptick;
        bit pcry;
    } mstate_t;

    typedef struct packed {
        logic       fwd;
        logic       rev;
        logic       busy;
        logic       done;
        logic [7:0] left;
    } exp_t;

    typedef exp_t [2:0] exp3_t;

    mstate_t ms [3];
    exp3_t   sb_q [$];
    bit      prev_done [3];

    function automatic mstate_t step(mstate_t s, int p, int q, int n, bit a,
                                     bit tk, bit st, bit sp, bit cr);
        mstate_t r;
        bit tev, cev;
        r   = s;
        tev = tk & ~s.ptick;
        cev = cr & ~s.pcry;
        r.ptick = tk;
        r.pcry  = cr;
        if (s.mode == 2) begin
            r.mode = 0;
        end else if (s.mode == 0) begin
            if (!sp && (st || (cev && a))) begin
                r.mode = 1;
                r.pos  = 0;
                r.left = n;
            end
        end else if (sp) begin
            r.mode = 0;
        end else begin
            if (tev) begin
                r.pos = s.pos + 1;
                if (r.pos == 2 * (p + q)) begin
                    r.pos = 0;
                    if (s.left == 1 && !cev) r.mode = 2;
                    else r.left = s.left - 1;
                end
            end
            if (cev) r.left = n;
        end
        return r;
    endfunction

    function automatic exp_t expect_of(mstate_t s, int p, int q);
        exp_t e;
        bit act;
        act    = (s.mode == 1);
        e.fwd  = act && (s.pos < p);
        e.rev  = act && (s.pos >= p + q) && (s.pos < 2 * p + q);
        e.busy = act;
        e.done = (s.mode == 2);
        e.left = act ? 8'(s.left) : 8'd0;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            ms[i].mode = 0; ms[i].pos = 0; ms[i].left = 0;
            ms[i].ptick = 1'b0; ms[i].pcry = 1'b0;
        end
    endtask

    task automatic drive(bit tk, bit st, bit sp, bit cr);
        exp3_t e;
        @(negedge CLK);
        Tick = tk; Start = st; Stop = sp; Cry = cr;
        for (int i = 0; i < 3; i++) begin
            ms[i] = step(ms[i], P_c[i], Q_c[i], N_c[i], A_c[i], tk, st, sp, cr);
            e[i]  = expect_of(ms[i], P_c[i], Q_c[i]);
        end
        sb_q.push_back(e);
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(int nev, int hold, int gap);
        repeat (nev) begin
            repeat (hold) drive(1'b1, 1'b0, 1'b0, 1'b0);
            repeat (gap) drive(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic reset_check(string tag);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({fwd_s[i], rev_s[i], busy_s[i], done_s[i], left_s[i]} !== 12'd0) begin
                errors++;
                $display("FAIL %s dut%0d: actual fwd=%b rev=%b busy=%b done=%b left=%0d, required all 0",
                         tag, i, fwd_s[i], rev_s[i], busy_s[i], done_s[i], left_s[i]);
            end
        end
    endtask

    // Monitor: invariants every cycle, scoreboard comparison whenever a prediction is pending.
    initial begin
        exp3_t e;
        exp_t  act;
        forever begin
            @(posedge CLK);
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (fwd_s[i] && rev_s[i]) begin
                    errors++;
                    $display("FAIL motor_excl dut%0d: actual fwd=1 rev=1, required not both", i);
                end
                checks++;
                if (done_s[i] && prev_done[i]) begin
                    errors++;
                    $display("FAIL done_width dut%0d: actual Done high 2 cycles, required 1", i);
                end
                prev_done[i] = done_s[i];
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    act = {fwd_s[i], rev_s[i], busy_s[i], done_s[i], left_s[i]};
                    checks++;
                    if (act !== e[i]) begin
                        errors++;
                        $display("FAIL sb dut%0d t=%0t: actual fwd=%b rev=%b busy=%b done=%b left=%0d required fwd=%b rev=%b busy=%b done=%b left=%0d",
                                 i, $time, act.fwd, act.rev, act.busy, act.done, act.left,
                                 e[i].fwd, e[i].rev, e[i].busy, e[i].done, e[i].left);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit cry_l;
        cry_l = 1'b0;
        for (int i = 0; i < 3; i++) prev_done[i] = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        reset_check("reset_hold");
        Reset = 1'b0;

        // Normal run with one-cycle ticks every 10 clocks
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(12, 1, 9);
        idle(5);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Stretched ticks, each held 3 cycles
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(12, 3, 7);
        idle(5);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Stop coinciding with a tick event while in REV
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3, 1, 4);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        idle(4);

        // Cry on the completion tick of the final swing
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(11, 1, 4);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);
        ticks(12, 1, 4);
        idle(3);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Cry between ticks while in the final pause
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(11, 1, 4);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(13, 1, 4);
        idle(3);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Cry in idle: auto-start instances begin, dut_b stays idle
        idle(2);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        ticks(2, 1, 3);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Start and Stop together in idle
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);

        // Asynchronous reset mid-FWD
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(1, 1, 3);
        @(posedge CLK);
        #3;
        Reset = 1'b1;
        #1;
        reset_check("reset_async");
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        model_reset();
        idle(5);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(12, 1, 4);
        idle(4);

        // Randomized traffic
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 24) == 0) cry_l = ~cry_l;
            drive(($urandom_range(0, 4) == 0), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 149) == 0), cry_l);
        end
        idle(3);
        @(posedge CLK);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: actual %0d pending, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
